// File: rtl/ram_if_pkg.sv
// Shared types and constants for the RAM command handshake responder.
// Error flag bit positions are fixed here so initiators and responders agree.
package ram_if_pkg;
    localparam int ADDR_W_DEF  = 26;
    localparam int DATA_W_DEF  = 8;
    localparam int ERR_RANGE   = 0;
    localparam int ERR_COLLIDE = 1;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_WRITE,
        ST_READ_WAIT,
        ST_PRESENT
    } state_t;
endpackage

// File: rtl/ram_sp_array.sv
// Single-port synchronous byte array with a one-cycle registered read.
// Read and write share one address; a read during a write returns the old word.
module ram_sp_array
    import ram_if_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  systemCLK,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);
    logic [DATA_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

    always_ff @(posedge systemCLK) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end
endmodule

// File: rtl/ram_responder.sv
// Responder side of the RAM command handshake, backed by an on-chip byte array.
// Clears storage after reset, serves reads after a fixed latency, flags protocol errors.
module ram_responder
    import ram_if_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int DEPTH_LOG2   = 12,
    parameter int READ_LATENCY = 3
) (
    input  logic              systemCLK,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    input  logic              write_enable,
    input  logic              read_request,
    input  logic              read_ack,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_data_pres,
    output logic              rdy,
    output logic [ADDR_W-1:0] max_ram_address,
    output logic [1:0]        err
);
    localparam logic [ADDR_W-1:0] MAX_ADDR =
        {{(ADDR_W-DEPTH_LOG2){1'b0}}, {DEPTH_LOG2{1'b1}}};

    state_t                state;
    state_t                state_next;
    logic [DEPTH_LOG2-1:0] clr_addr;
    logic [3:0]            lat_cnt;
    logic [ADDR_W-1:0]     cmd_addr_p0;
    logic [DATA_W-1:0]     cmd_data_p0;
    logic                  cmd_in_range;
    logic                  accept_wr;
    logic                  accept_rd;
    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_rdata;

    assign max_ram_address = MAX_ADDR;
    assign cmd_in_range    = (cmd_addr_p0 <= MAX_ADDR);
    // A simultaneous write and read is a collision: the write wins.
    assign accept_wr       = rdy & write_enable;
    assign accept_rd       = rdy & read_request & ~write_enable;

    always_ff @(posedge systemCLK) begin
        if (reset) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_CLEAR:     if (clr_addr == '1) state_next = ST_IDLE;
            ST_IDLE,
            ST_PRESENT: begin
                if (write_enable) begin
                    state_next = ST_WRITE;
                end else if (read_request) begin
                    state_next = ST_READ_WAIT;
                end else if (state == ST_PRESENT && read_ack) begin
                    state_next = ST_IDLE;
                end
            end
            ST_WRITE:     state_next = ST_IDLE;
            ST_READ_WAIT: if (lat_cnt == 4'd0) state_next = ST_PRESENT;
            default:      state_next = ST_CLEAR;
        endcase
    end

    always_comb begin
        rdy          = 1'b0;
        rd_data_pres = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = cmd_addr_p0[DEPTH_LOG2-1:0];
        mem_wdata    = cmd_data_p0;
        case (state)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_addr  = clr_addr;
                mem_wdata = '0;
            end
            ST_IDLE:    rdy = 1'b1;
            ST_WRITE:   mem_we = cmd_in_range;
            ST_PRESENT: begin
                rdy          = 1'b1;
                rd_data_pres = 1'b1;
            end
            default: ;
        endcase
    end

    // Command capture: data-path registers, no reset needed.
    always_ff @(posedge systemCLK) begin
        if (accept_wr || accept_rd) begin
            cmd_addr_p0 <= address;
        end
        if (accept_wr) begin
            cmd_data_p0 <= data_in;
        end
    end

    // Control: clear sweep, read latency countdown, read result and sticky errors.
    always_ff @(posedge systemCLK) begin
        if (reset) begin
            clr_addr <= '0;
            lat_cnt  <= '0;
            data_out <= '0;
            err      <= '0;
        end else begin
            if (state == ST_CLEAR) begin
                clr_addr <= clr_addr + 1'b1;
            end
            if (accept_wr) begin
                if (address > MAX_ADDR) err[ERR_RANGE] <= 1'b1;
                if (read_request) err[ERR_COLLIDE] <= 1'b1;
            end
            if (accept_rd) begin
                lat_cnt <= 4'(READ_LATENCY);
            end
            if (state == ST_READ_WAIT) begin
                if (lat_cnt == 4'd0) begin
                    data_out <= cmd_in_range ? mem_rdata : '0;
                    if (!cmd_in_range) err[ERR_RANGE] <= 1'b1;
                end else begin
                    lat_cnt <= lat_cnt - 1'b1;
                end
            end
        end
    end

    ram_sp_array #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .systemCLK (systemCLK),
        .we        (mem_we),
        .addr      (mem_addr),
        .wdata     (mem_wdata),
        .rdata     (mem_rdata)
    );
endmodule

// File: tb/tb_ram_responder.sv
// Self-checking bench for ram_responder: directed table, multi-cycle corner
// sequences and randomized traffic against a byte-array reference model.
module tb_ram_responder;
    localparam int ADDR_W       = 26;
    localparam int DATA_W       = 8;
    localparam int DEPTH_LOG2   = 12;
    localparam int READ_LATENCY = 3;
    localparam int DEPTH        = 1 << DEPTH_LOG2;

    logic              systemCLK;
    logic              reset;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_in;
    logic              write_enable;
    logic              read_request;
    logic              read_ack;
    logic [DATA_W-1:0] data_out;
    logic              rd_data_pres;
    logic              rdy;
    logic [ADDR_W-1:0] max_ram_address;
    logic [1:0]        err;

    ram_responder #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .DEPTH_LOG2   (DEPTH_LOG2),
        .READ_LATENCY (READ_LATENCY)
    ) dut (
        .systemCLK       (systemCLK),
        .reset           (reset),
        .address         (address),
        .data_in         (data_in),
        .write_enable    (write_enable),
        .read_request    (read_request),
        .read_ack        (read_ack),
        .data_out        (data_out),
        .rd_data_pres    (rd_data_pres),
        .rdy             (rdy),
        .max_ram_address (max_ram_address),
        .err             (err)
    );

    initial systemCLK = 1'b0;
    always #5 systemCLK = ~systemCLK;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] ref_mem [DEPTH];
    logic [1:0] ref_err;

    typedef struct {
        string       name;
        bit          is_write;
        logic [25:0] addr;
        logic [7:0]  data;
        logic [7:0]  exp_data;
        logic [1:0]  exp_err;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge systemCLK);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
        ref_err = 2'b00;
    endtask

    task automatic model_write(input logic [25:0] a, input logic [7:0] d, input bit collide);
        if (a < DEPTH) ref_mem[a[DEPTH_LOG2-1:0]] = d;
        else ref_err[0] = 1'b1;
        if (collide) ref_err[1] = 1'b1;
    endtask

    task automatic model_read(input logic [25:0] a, output logic [7:0] d);
        if (a < DEPTH) begin
            d = ref_mem[a[DEPTH_LOG2-1:0]];
        end else begin
            d = 8'h00;
            ref_err[0] = 1'b1;
        end
    endtask

    task automatic do_reset();
        int  cyc;
        bit  pres_seen;
        reset        = 1'b1;
        write_enable = 1'b0;
        read_request = 1'b0;
        read_ack     = 1'b0;
        step();
        reset = 1'b0;
        model_clear();
        check("reset_pres", rd_data_pres, 0);
        check("reset_err", err, 0);
        check("reset_rdy", rdy, 0);
        check("reset_dout", data_out, 0);
        cyc       = 0;
        pres_seen = 1'b0;
        while (!rdy && cyc < 5000) begin
            step();
            cyc++;
            pres_seen |= rd_data_pres;
        end
        check("clear_cycles", cyc, DEPTH);
        check("clear_pres", pres_seen, 0);
    endtask

    task automatic wait_rdy();
        int cyc;
        cyc = 0;
        while (!rdy && cyc < 50) begin
            step();
            cyc++;
        end
        check("wait_rdy", rdy, 1);
    endtask

    task automatic do_write(input logic [25:0] a, input logic [7:0] d, input bit collide);
        wait_rdy();
        address      = a;
        data_in      = d;
        write_enable = 1'b1;
        read_request = collide;
        step();
        write_enable = 1'b0;
        read_request = 1'b0;
        model_write(a, d, collide);
        check("wr_busy_rdy", rdy, 0);
        check("wr_pres_drop", rd_data_pres, 0);
        step();
        check("wr_done_rdy", rdy, 1);
        check("wr_no_pres", rd_data_pres, 0);
    endtask

    task automatic do_read(input logic [25:0] a, input bit ack,
                           output logic [7:0] got, output logic [7:0] exp);
        int lat;
        wait_rdy();
        address      = a;
        read_request = 1'b1;
        step();
        read_request = 1'b0;
        model_read(a, exp);
        check("rd_busy_rdy", rdy, 0);
        check("rd_pres_drop", rd_data_pres, 0);
        lat = 0;
        while (!rd_data_pres && lat < 40) begin
            step();
            lat++;
        end
        check("rd_latency", lat, READ_LATENCY + 1);
        check("rd_present_rdy", rdy, 1);
        got = data_out;
        if (ack) begin
            read_ack = 1'b1;
            step();
            read_ack = 1'b0;
            check("ack_drop", rd_data_pres, 0);
            check("ack_dout_held", data_out, got);
        end
    endtask

    initial begin
        logic [7:0]  got;
        logic [7:0]  exp;
        logic [25:0] a;
        bit          seen;

        reset        = 1'b1;
        address      = '0;
        data_in      = '0;
        write_enable = 1'b0;
        read_request = 1'b0;
        read_ack     = 1'b0;

        vecs[0] = '{"rd_0",        1'b0, 26'h0000000, 8'h00, 8'h00, 2'b00};
        vecs[1] = '{"rd_100",      1'b0, 26'd100,     8'h00, 8'h00, 2'b00};
        vecs[2] = '{"rd_4095",     1'b0, 26'd4095,    8'h00, 8'h00, 2'b00};
        vecs[3] = '{"wr_010",      1'b1, 26'h0000010, 8'hA5, 8'h00, 2'b00};
        vecs[4] = '{"rd_010",      1'b0, 26'h0000010, 8'h00, 8'hA5, 2'b00};
        vecs[5] = '{"wr_1000_oor", 1'b1, 26'h0001000, 8'h3C, 8'h00, 2'b01};
        vecs[6] = '{"rd_1000_oor", 1'b0, 26'h0001000, 8'h00, 8'h00, 2'b01};
        vecs[7] = '{"rd_0_alias",  1'b0, 26'h0000000, 8'h00, 8'h00, 2'b01};

        do_reset();
        check("max_ram_address", max_ram_address, 26'h0000FFF);

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].is_write) begin
                do_write(vecs[i].addr, vecs[i].data, 1'b0);
            end else begin
                do_read(vecs[i].addr, 1'b1, got, exp);
                check(vecs[i].name, got, vecs[i].exp_data);
            end
            check({vecs[i].name, "_err"}, err, vecs[i].exp_err);
        end

        // New read issued while a previous result is still presented.
        do_write(26'h011, 8'h5A, 1'b0);
        do_read(26'h010, 1'b0, got, exp);
        check("present_first", got, 8'hA5);
        check("present_held", rd_data_pres, 1);
        do_read(26'h011, 1'b1, got, exp);
        check("present_second", got, 8'h5A);

        // Reset while a read is in READ_WAIT.
        wait_rdy();
        address      = 26'h010;
        read_request = 1'b1;
        step();
        read_request = 1'b0;
        step();
        check("rw_pres", rd_data_pres, 0);
        do_reset();
        do_read(26'h010, 1'b1, got, exp);
        check("post_reset_read", got, 8'h00);
        check("post_reset_err", err, 2'b00);

        // Write and read pulsed together.
        do_write(26'h020, 8'h77, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < READ_LATENCY + 4; i++) begin
            step();
            seen |= rd_data_pres;
        end
        check("coll_no_pres", seen, 0);
        check("coll_err", err, 2'b10);
        do_read(26'h020, 1'b1, got, exp);
        check("coll_read", got, 8'h77);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0) a = 26'(DEPTH + $urandom_range(0, 300));
            else a = 26'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, 8'($urandom_range(0, 255)), 1'b0);
            end else begin
                do_read(a, 1'($urandom_range(0, 1)), got, exp);
                check("rand_read", got, exp);
            end
            check("rand_err", err, ref_err);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
